// File: rtl/sequence_controller.sv
// Sequences the note RAM: full clear, record/overdub of live keys and playback, one address per sample tick.
// Latency tick->notes_out: 2 cycles (play), NOTES+2 (record); no backpressure, buttons are levels.
module sequence_controller #(
  parameter int ADDR_W   = 11,
  parameter int LEN      = 1875,
  parameter int NOTES    = 5,
  parameter int TICK_DIV = 133333
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              record,
  input  logic              clear,
  input  logic [NOTES-1:0]  key_in,
  input  logic [NOTES-1:0]  ram_out,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write,
  output logic              ram_reset,
  output logic              ram_in,
  output logic [2:0]        ram_note,
  output logic [NOTES-1:0]  notes_out,
  output logic              busy,
  output logic              loop_wrap,
  output logic              clear_done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  TICK_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);
  localparam logic [2:0]        LAST_IDX  = 3'(NOTES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, WAIT, WRITE, READ, LATCH} state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             rec;
  logic [NOTES-1:0] key_snap;
  logic [2:0]       idx;

  assign tick = (tick_cnt == TICK_MAX);
  assign busy = (state != IDLE);

  // Sample clock only runs while a sequence is active, so every run starts on a fresh slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (state == IDLE || state == CLEAR || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ram_address <= '0;
      ram_write   <= 1'b0;
      ram_reset   <= 1'b0;
      ram_in      <= 1'b0;
      ram_note    <= '0;
      notes_out   <= '0;
      loop_wrap   <= 1'b0;
      clear_done  <= 1'b0;
      rec         <= 1'b0;
      key_snap    <= '0;
      idx         <= '0;
    end else begin
      loop_wrap  <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          ram_address <= '0;
          notes_out   <= '0;
          if (clear) begin
            state     <= CLEAR;
            ram_reset <= 1'b1;
          end else if (record) begin
            state <= WAIT;
            rec   <= 1'b1;
          end else if (play) begin
            state <= WAIT;
            rec   <= 1'b0;
          end
        end

        CLEAR: begin
          ram_write <= 1'b0;
          if (ram_address == LAST_ADDR) begin
            ram_reset   <= 1'b0;
            ram_address <= '0;
            clear_done  <= 1'b1;
            state       <= IDLE;
          end else begin
            ram_address <= ram_address + ADDR_W'(1);
          end
        end

        WAIT: begin
          if (!play && !record) begin
            state       <= IDLE;
            notes_out   <= '0;
            ram_address <= '0;
          end else if (tick) begin
            // Mode changes only land on a sample boundary.
            rec      <= record;
            key_snap <= key_in;
            if (record) begin
              state     <= WRITE;
              idx       <= '0;
              ram_note  <= '0;
              ram_in    <= 1'b1;
              ram_write <= key_in[0];
            end else begin
              state <= READ;
            end
          end
        end

        WRITE: begin
          // Only held keys raise the write strobe, so overdub can set bits but never clear them.
          if (idx == LAST_IDX) begin
            state     <= READ;
            ram_write <= 1'b0;
            ram_in    <= 1'b0;
            ram_note  <= '0;
          end else begin
            idx       <= idx + 3'd1;
            ram_note  <= idx + 3'd1;
            ram_write <= key_snap[idx + 3'd1];
          end
        end

        READ: begin
          state <= LATCH;
        end

        LATCH: begin
          notes_out <= rec ? (ram_out | key_snap) : ram_out;
          if (ram_address == LAST_ADDR) begin
            ram_address <= '0;
            loop_wrap   <= 1'b1;
          end else begin
            ram_address <= ram_address + ADDR_W'(1);
          end
          state <= WAIT;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_controller.sv
// Randomized bench for sequence_controller: a bit-addressable RAM stand-in plus a slot-level
// model (address = slot number mod LEN, overdub = OR into the stored word).
module tb_sequence_controller;

  localparam int ADDR_W   = 4;
  localparam int LEN      = 16;
  localparam int NOTES    = 5;
  localparam int TICK_DIV = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              play, record, clear;
  logic [NOTES-1:0]  key_in;
  logic [NOTES-1:0]  ram_out;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_write, ram_reset, ram_in;
  logic [2:0]        ram_note;
  logic [NOTES-1:0]  notes_out;
  logic              busy, loop_wrap, clear_done;

  always #5 clk = ~clk;

  sequence_controller #(
    .ADDR_W(ADDR_W), .LEN(LEN), .NOTES(NOTES), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .record(record), .clear(clear),
    .key_in(key_in), .ram_out(ram_out), .ram_address(ram_address),
    .ram_write(ram_write), .ram_reset(ram_reset), .ram_in(ram_in),
    .ram_note(ram_note), .notes_out(notes_out), .busy(busy),
    .loop_wrap(loop_wrap), .clear_done(clear_done)
  );

  // RAM stand-in: word clear, single-bit write, registered read; fill seeds garbage.
  logic [NOTES-1:0] mem [LEN];
  logic             fill = 1'b1;
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < LEN; i++) mem[i] <= NOTES'($urandom);
    end else if (ram_reset) begin
      mem[ram_address] <= '0;
    end else if (ram_write) begin
      mem[ram_address][ram_note] <= ram_in;
    end
    ram_out <= mem[ram_address];
  end

  logic [NOTES-1:0] ref_mem [LEN];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int drop_c = -100;
  int wrap_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (loop_wrap)  wrap_cnt++;
    if (clear_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (cyc == drop_c) begin
      play   = 1'b0;
      record = 1'b0;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_notes"}, 32'(notes_out), 32'd0);
    chk({tag, "_addr"}, 32'(ram_address), 32'd0);
    chk({tag, "_wr"}, 32'(ram_write), 32'd0);
    chk({tag, "_rst"}, 32'(ram_reset), 32'd0);
  endtask

  task automatic compare_mem(input string tag);
    for (int a = 0; a < LEN; a++) chk(tag, 32'(mem[a]), 32'(ref_mem[a]));
  endtask

  task automatic do_clear(input bit with_others);
    int d0;
    d0 = done_cnt;
    clear = 1'b1; record = with_others; play = with_others;
    @(negedge clk);
    clear = 1'b0; record = 1'b0; play = 1'b0;
    for (int a = 0; a < LEN; a++) begin
      chk("clr_reset", 32'(ram_reset), 32'd1);
      chk("clr_addr", 32'(ram_address), 32'(a));
      chk("clr_wr", 32'(ram_write), 32'd0);
      if (a < LEN - 1) begin
        clear = 1'($urandom); record = 1'($urandom); play = 1'($urandom);
      end else begin
        clear = 1'b0; record = 1'b0; play = 1'b0;
      end
      @(negedge clk);
    end
    chk("clr_done", 32'(clear_done), 32'd1);
    chk_quiet("clr_end");
    @(negedge clk);
    chk("clr_done_low", 32'(clear_done), 32'd0);
    #1;
    chk("clr_done_cnt", 32'(done_cnt - d0), 32'd1);
    for (int a = 0; a < LEN; a++) ref_mem[a] = '0;
    compare_mem("clr_mem");
  endtask

  // One run from IDLE: nslots sample slots, then buttons drop drop_off cycles after the last tick.
  // abort_idx >= 0 pulls reset during the first slot's write of that bit instead.
  task automatic run_seq(input bit rec_mode, input int nslots, input bit use_fixed,
                         input logic [NOTES-1:0] fixed_key, input int drop_off, input int abort_idx);
    int lat, e, a, w0, exp_wraps;
    logic [NOTES-1:0] k, exp_n, prev_n;
    lat = rec_mode ? NOTES + 2 : 2;
    a = 0; prev_n = '0; exp_wraps = 0; w0 = wrap_cnt;
    drop_c = -100; cyc = -1;
    record = rec_mode;
    play = rec_mode ? 1'($urandom) : 1'b1;
    step();
    for (int j = 0; j < nslots; j++) begin
      e = TICK_DIV * (j + 1);
      while (cyc < e - 1) step();
      k = use_fixed ? fixed_key : NOTES'($urandom);
      key_in = k;
      chk("run_busy", 32'(busy), 32'd1);
      if (j == nslots - 1 && abort_idx < 0) drop_c = e + drop_off;
      step();
      key_in = NOTES'($urandom);
      if (rec_mode) begin
        for (int i = 0; i < NOTES; i++) begin
          if (i > 0) step();
          if (i == abort_idx) begin
            reset = 1'b0;
            #1;
            chk_quiet("abort");
            chk("abort_note", 32'(ram_note), 32'd0);
            chk("abort_in", 32'(ram_in), 32'd0);
            chk("abort_wrap", 32'(loop_wrap), 32'd0);
            chk("abort_done", 32'(clear_done), 32'd0);
            ref_mem[a] = ref_mem[a] | (k & NOTES'((1 << abort_idx) - 1));
            record = 1'b0; play = 1'b0; key_in = '0;
            @(negedge clk);
            reset = 1'b1;
            return;
          end
          chk("wr_note", 32'(ram_note), 32'(i));
          chk("wr_en", 32'(ram_write), 32'(k[i]));
          chk("wr_data", 32'(ram_in), 32'd1);
          chk("wr_addr", 32'(ram_address), 32'(a));
        end
        ref_mem[a] = ref_mem[a] | k;
      end
      exp_n = ref_mem[a];
      while (cyc < e + lat - 1) step();
      chk("hold", 32'(notes_out), 32'(prev_n));
      chk("rd_nowrite", 32'(ram_write), 32'd0);
      step();
      chk("notes", 32'(notes_out), 32'(exp_n));
      chk("wrap", 32'(loop_wrap), 32'(a == LEN - 1));
      if (a == LEN - 1) exp_wraps++;
      a = (a + 1) % LEN;
      chk("next_addr", 32'(ram_address), 32'(a));
      prev_n = exp_n;
    end
    step();
    chk_quiet("stop");
    #1;
    chk("wrap_cnt", 32'(wrap_cnt - w0), 32'(exp_wraps));
    drop_c = -100;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit r;
    int n;
    play = 1'b0; record = 1'b0; clear = 1'b0; key_in = '0;
    for (int a = 0; a < LEN; a++) ref_mem[a] = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    fill = 1'b0;
    chk_quiet("reset");
    chk("reset_note", 32'(ram_note), 32'd0);
    chk("reset_in", 32'(ram_in), 32'd0);
    chk("reset_wrap", 32'(loop_wrap), 32'd0);
    chk("reset_done", 32'(clear_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'(busy), 32'd0);

    do_clear(1'b1);
    run_seq(1'b1, 3, 1'b1, 5'b00101, 3, -1);
    compare_mem("rec_mem");
    run_seq(1'b1, 1, 1'b1, 5'b10000, 1, -1);
    chk("merge", 32'(mem[0]), 32'h15);
    run_seq(1'b1, 18, 1'b0, '0, int'($urandom_range(1, NOTES + 2)), -1);
    compare_mem("rec2_mem");
    run_seq(1'b0, 20, 1'b0, '0, int'($urandom_range(1, 2)), -1);
    for (int t = 0; t < 4; t++) begin
      r = 1'($urandom);
      n = int'($urandom_range(1, 20));
      run_seq(r, n, 1'b0, '0, int'($urandom_range(1, r ? NOTES + 2 : 2)), -1);
    end
    compare_mem("mix_mem");

    do_clear(1'b0);
    run_seq(1'b0, 3, 1'b0, '0, 2, -1);
    run_seq(1'b1, 1, 1'b1, 5'b11111, 1, 2);
    compare_mem("abort_mem");
    chk("abort_bits", 32'(mem[0]), 32'h03);
    run_seq(1'b0, 1, 1'b0, '0, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
